seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 2..8).
REQ-002 SHALL provide parameter REFRESH_DIV, default 65536, clock cycles per digit slot (legal >= GUARD_CYCLES+2).
REQ-003 SHALL provide parameter GUARD_CYCLES, default 16, anti-ghosting blank cycles at the start of each slot (legal 0..REFRESH_DIV-2).
REQ-004 SHALL provide parameter BLINK_FRAMES, default 32, frames per blink half-period (legal >= 1).
REQ-005 SHALL provide port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 SHALL provide port reset_n, input, 1, synchronous active-low reset.
REQ-007 SHALL provide port bcd_value, input, 4*NUM_DIGITS, digit codes; nibble i drives digit i, where digit 0 is least significant.
REQ-008 SHALL provide port dp_mask, input, NUM_DIGITS, decimal point enable per digit.
REQ-009 SHALL provide port blink_mask, input, NUM_DIGITS, blink enable per digit.
REQ-010 SHALL provide port hex_mode, input, 1: 1 = codes 10..15 show A..F; 0 = codes 10..15 show blank.
REQ-011 SHALL provide port blank_lz, input, 1, leading-zero blanking enable.
REQ-012 SHALL provide port negative, input, 1: shows minus sign on digit NUM_DIGITS-1.
REQ-013 SHALL provide port update, input, 1, strobe; captures all data and mode inputs.
REQ-014 SHALL provide port cathodes, output, 8, active-low segments; [7:1] = a..g, [0] = dp.
REQ-015 SHALL provide port anodes, output, NUM_DIGITS, active-low digit enables.
REQ-016 SHALL provide port frame_done, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-017 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, slot index SHALL advance, and SHALL wrap from NUM_DIGITS-1 to 0.
REQ-018 Frame boundary SHALL be the cycle in which slot advances from NUM_DIGITS-1 to 0; frame_done SHALL be 1 in exactly the following output cycle.
REQ-019 update=1 SHALL copy bcd_value, dp_mask, blink_mask, hex_mode, blank_lz and negative into a staging register and set pending.
REQ-020 At a frame boundary with pending=1, the display register SHALL load staging and clear pending; values SHALL never change mid-frame (no tearing).
REQ-021 If update and a frame boundary coincide, the display register SHALL load the live inputs directly and pending SHALL end 0.
REQ-022 Repeated update within one frame: the last strobe SHALL win.
REQ-023 anodes and cathodes SHALL be registered and lag the slot and prescaler state by exactly 1 cycle.
REQ-024 While prescaler < GUARD_CYCLES, anodes SHALL be all 1 and cathodes 8'hFF.
REQ-025 Otherwise anodes SHALL have only bit [slot] at 0.
REQ-026 Digit code patterns ([7:0]) SHALL be:
- 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
- 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
- A=00010001, b=11000001, C=01100011, d=10000101, E=01100001, F=01110001
REQ-027 Minus pattern SHALL be 1111110x, where x is the dp bit.
REQ-028 Precedence per slot, highest first: blink-off, minus, leading-zero blank, code decode.
REQ-029 Blink phase SHALL toggle every BLINK_FRAMES frame boundaries; in phase 1, a slot with blink_mask bit set SHALL output cathodes 8'hFF with its anode still active.
REQ-030 negative=1 SHALL display minus on digit NUM_DIGITS-1 regardless of its code.
REQ-031 blank_lz=1 SHALL blank digit i (1 <= i <= NUM_DIGITS-1, excluding the minus digit) when digit i and all higher non-minus digits are 0; digit 0 SHALL never be leading-zero blanked.
REQ-032 Decimal point (cathodes[0]=0) SHALL follow dp_mask even on leading-zero-blanked digits, but SHALL be suppressed by blink-off and guard.

Reset
REQ-033 When reset_n=0 at a clock edge, the next state SHALL be:
- cathodes=8'hFF, anodes all 1, frame_done=0
- prescaler=0, slot=0, pending=0, blink phase=0
- staging and display registers all 0
REQ-034 Reset mid-frame SHALL discard pending data; the first post-reset frame SHALL display all-zero codes, with no dp, minus or blink.

Verification
REQ-035 NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, update with bcd_value=16'h1234 -> after the next frame boundary, slot 0 shows 10011001 with anodes=1110 for 6 of every 8 cycles, and 1111 during the 2 guard cycles.
REQ-036 blank_lz=1, bcd_value=16'h0050, dp_mask=4'b0100 -> digit3 cathodes 8'hFF; digit2 cathodes 11111110 (dp only); digit1 shows 5; digit0 shows 0.
REQ-037 hex_mode=0 then 1 with nibble 4'hB -> 8'hFF, then 11000001; negative=1 -> digit3 shows 11111101.
REQ-038 update asserted mid-frame with 16'h9999 -> the current frame finishes with the old value; 16'h9999 appears from the next frame; frame_done pulses once per 4*REFRESH_DIV cycles.
REQ-039 BLINK_FRAMES=2, blink_mask=4'b0001 -> digit0 alternates visible and 8'hFF every 2 frames; other digits stay unaffected.
REQ-040 reset_n=0 for one cycle while pending=1 -> next cycle outputs cathodes=8'hFF and all anodes 1; the following frame shows all-zero codes.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner with frame-synchronous (tear-free) data updates,
// anti-ghosting guard blanking, per-digit blink, minus sign and leading-zero blanking.
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 65536,
    parameter int GUARD_CYCLES = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic                    negative,
    input  logic                    update,
    output logic [7:0]              cathodes,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] bcd;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink;
        logic                    hex;
        logic                    blz;
        logic                    neg;
    } cfg_t;

    logic [PW-1:0]         presc_q, presc_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic                  pending_q, pending_d;
    cfg_t                  stage_q, stage_d;
    cfg_t                  disp_q, disp_d;
    logic [7:0]            cath_q, cath_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fdone_q, fdone_d;

    cfg_t                  live;
    logic                  wrap, boundary, guard;
    logic                  zero_above, is_minus;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            code;
    logic                  dp_on, blink_on, lz_on, minus_on;

    // Pattern bits [7:1] (a..g, active low); dp is appended separately.
    function automatic logic [6:0] decode(input logic [3:0] c, input logic hex);
        logic [6:0] seg;
        seg = 7'h7F;
        case (c)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = hex ? 7'b0001000 : 7'h7F;
            4'hB: seg = hex ? 7'b1100000 : 7'h7F;
            4'hC: seg = hex ? 7'b0110001 : 7'h7F;
            4'hD: seg = hex ? 7'b1000010 : 7'h7F;
            4'hE: seg = hex ? 7'b0110000 : 7'h7F;
            default: seg = hex ? 7'b0111000 : 7'h7F;
        endcase
        return seg;
    endfunction

    always_comb begin
        live     = {bcd_value, dp_mask, blink_mask, hex_mode, blank_lz, negative};
        wrap     = (presc_q == PW'(REFRESH_DIV - 1));
        boundary = wrap && (slot_q == SW'(NUM_DIGITS - 1));
        presc_d  = wrap ? '0 : presc_q + 1'b1;
        slot_d   = slot_q;
        if (wrap) slot_d = boundary ? '0 : slot_q + 1'b1;
        fdone_d  = boundary;

        stage_d   = stage_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        if (update) begin
            stage_d   = live;
            pending_d = 1'b1;
        end
        // A strobe landing on the boundary bypasses staging so it is not delayed a frame.
        if (boundary) begin
            if (update) begin
                disp_d    = live;
                pending_d = 1'b0;
            end else if (pending_q) begin
                disp_d    = stage_q;
                pending_d = 1'b0;
            end
        end

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (boundary) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        // Scan from the top digit down; the minus digit neither blanks nor breaks the zero run.
        zero_above = 1'b1;
        lz         = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            is_minus = disp_q.neg && (i == NUM_DIGITS - 1);
            if (!is_minus) zero_above = zero_above && (disp_q.bcd[4*i +: 4] == 4'h0);
            lz[i] = disp_q.blz && (i != 0) && !is_minus && zero_above;
        end

        code     = 4'h0;
        dp_on    = 1'b0;
        blink_on = 1'b0;
        lz_on    = 1'b0;
        minus_on = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SW'(i)) begin
                code     = disp_q.bcd[4*i +: 4];
                dp_on    = disp_q.dp[i];
                blink_on = disp_q.blink[i];
                lz_on    = lz[i];
                minus_on = disp_q.neg && (i == NUM_DIGITS - 1);
            end
        end

        guard  = (presc_q < PW'(GUARD_CYCLES));
        an_d   = '1;
        cath_d = 8'hFF;
        if (!guard) begin
            for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (slot_q != SW'(i));
            if (blink_on && phase_q)  cath_d = 8'hFF;
            else if (minus_on)        cath_d = {7'b1111110, ~dp_on};
            else if (lz_on)           cath_d = {7'h7F, ~dp_on};
            else                      cath_d = {decode(code, disp_q.hex), ~dp_on};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q   <= '0;
            slot_q    <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            pending_q <= 1'b0;
            stage_q   <= '0;
            disp_q    <= '0;
            cath_q    <= 8'hFF;
            an_q      <= '1;
            fdone_q   <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            slot_q    <= slot_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            stage_q   <= stage_d;
            disp_q    <= disp_d;
            cath_q    <= cath_d;
            an_q      <= an_d;
            fdone_q   <= fdone_d;
        end
    end

    assign cathodes   = cath_q;
    assign anodes     = an_q;
    assign frame_done = fdone_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (4 digits, 8-cycle slots, 2 guard cycles, 2-frame blink):
// vector table of display settings plus a frame-level scoreboard of expected cathodes.
module tb_seg_scan_mux;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 2;
    localparam int BF = 2;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [15:0]   bcd_value;
    logic [3:0]    dp_mask, blink_mask;
    logic          hex_mode, blank_lz, negative, update;
    logic [7:0]    cathodes;
    logic [3:0]    anodes;
    logic          frame_done;

    seg_scan_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .bcd_value(bcd_value), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .hex_mode(hex_mode), .blank_lz(blank_lz),
        .negative(negative), .update(update), .cathodes(cathodes), .anodes(anodes),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp, blink;
        logic        hex, blz, neg;
        logic [31:0] exp;       // expected visible cathodes, digit i at [8*i +: 8]
    } vec_t;

    typedef struct {
        logic [31:0] cath;
        logic [3:0]  blink;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;
    bit     tb_pending, phase, periodic;
    int     bcnt;
    int     checks = 0;
    int     errors = 0;
    vec_t   vecs[12];
    int     ups[12];
    vec_t   none;

    function automatic vec_t mk(input logic [15:0] bcd, input logic [3:0] dp, input logic [3:0] blink,
                                input logic hex, input logic blz, input logic neg, input logic [31:0] e);
        vec_t v;
        v.bcd = bcd; v.dp = dp; v.blink = blink; v.hex = hex; v.blz = blz; v.neg = neg; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        cur.cath   = {4{8'h03}};
        cur.blink  = 4'b0000;
        exp_q.delete();
        tb_pending = 1'b0;
        phase      = 1'b0;
        bcnt       = 0;
        periodic   = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        frame_t f;
        bcd_value = v.bcd; dp_mask = v.dp; blink_mask = v.blink;
        hex_mode = v.hex; blank_lz = v.blz; negative = v.neg;
        update = 1'b1;
        f.cath = v.exp;
        f.blink = v.blink;
        exp_q.push_back(f);
        tb_pending = 1'b1;
    endtask

    task automatic wait_boundary();
        int waited = 0;
        bit got = 1'b0;
        while (!got && waited < 3 * FRAME) begin
            @(negedge clk);
            waited++;
            if (frame_done === 1'b1) got = 1'b1;
        end
        update = 1'b0;
        check("frame_done_seen", 32'(got), 32'd1);
        if (periodic) check("frame_period", 32'(waited), 32'd1);
        if (tb_pending) begin
            while (exp_q.size() > 0) cur = exp_q.pop_front();
            tb_pending = 1'b0;
        end
        bcnt++;
        if (bcnt == BF) begin
            bcnt  = 0;
            phase = ~phase;
        end
    endtask

    // Checks cycles 1..FRAME-1 of a frame; the frame_done of the next boundary is left for the next call.
    task automatic run_frame(input bit skip_wait, input int upd_a, input vec_t va,
                             input int upd_b, input vec_t vb);
        logic [3:0] ea;
        logic [7:0] ec;
        int p, s;
        if (!skip_wait) wait_boundary();
        for (int n = 1; n < FRAME; n++) begin
            @(negedge clk);
            p  = (n - 1) % RD;
            s  = (n - 1) / RD;
            ea = 4'b1111;
            ec = 8'hFF;
            if (p >= GC) begin
                ea[s] = 1'b0;
                ec = (phase && cur.blink[s]) ? 8'hFF : cur.cath[8*s +: 8];
            end
            check("anodes", 32'(anodes), 32'(ea));
            check("cathodes", 32'(cathodes), 32'(ec));
            check("frame_done_low", 32'(frame_done), 32'd0);
            if (n == upd_a)                        drive(va);
            else if (n == upd_b)                   drive(vb);
            else if (n == upd_a + 1 || n == upd_b + 1) update = 1'b0;
        end
        periodic = 1'b1;
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        update  = 1'b0;
        repeat (cycles) @(negedge clk);
        check("rst_cathodes", 32'(cathodes), 32'h0000_00FF);
        check("rst_anodes", 32'(anodes), 32'h0000_000F);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        vecs[0]  = mk(16'h1234, 4'b0000, 4'b0000, 0, 0, 0, {8'h9F, 8'h25, 8'h0D, 8'h99});
        vecs[1]  = mk(16'h0050, 4'b0100, 4'b0000, 0, 1, 0, {8'hFF, 8'hFE, 8'h49, 8'h03});
        vecs[2]  = mk(16'h000B, 4'b0000, 4'b0000, 0, 0, 0, {8'h03, 8'h03, 8'h03, 8'hFF});
        vecs[3]  = mk(16'h000B, 4'b0000, 4'b0000, 1, 0, 0, {8'h03, 8'h03, 8'h03, 8'hC1});
        vecs[4]  = mk(16'h1234, 4'b0000, 4'b0000, 0, 0, 1, {8'hFD, 8'h25, 8'h0D, 8'h99});
        vecs[5]  = mk(16'h0007, 4'b1000, 4'b0000, 0, 1, 1, {8'hFC, 8'hFF, 8'hFF, 8'h1F});
        vecs[6]  = mk(16'h0C00, 4'b0001, 4'b0000, 1, 1, 0, {8'hFF, 8'h63, 8'h03, 8'h02});
        vecs[7]  = mk(16'h0000, 4'b0000, 4'b0000, 0, 1, 0, {8'hFF, 8'hFF, 8'hFF, 8'h03});
        vecs[8]  = mk(16'h9999, 4'b0000, 4'b0000, 0, 0, 0, {8'h09, 8'h09, 8'h09, 8'h09});
        vecs[9]  = mk(16'hFEDC, 4'b1111, 4'b0000, 1, 0, 0, {8'h70, 8'h60, 8'h84, 8'h62});
        vecs[10] = mk(16'hFA98, 4'b0000, 4'b0000, 0, 0, 0, {8'hFF, 8'hFF, 8'h09, 8'h01});
        vecs[11] = mk(16'h8888, 4'b0000, 4'b0001, 0, 0, 0, {8'h01, 8'h01, 8'h01, 8'h01});
        ups = '{3, 10, 31, 17, 2, 25, 31, 8, 15, 1, 30, 6};
        none = mk(16'h0, 4'h0, 4'h0, 0, 0, 0, 32'h0);

        bcd_value = 16'h0; dp_mask = 4'h0; blink_mask = 4'h0;
        hex_mode = 1'b0; blank_lz = 1'b0; negative = 1'b0;
        apply_reset(3);
        run_frame(1, 0, none, 0, none);

        // Each vector is strobed mid-frame (or on the boundary) and checked in the following frame.
        for (int i = 0; i < 12; i++) run_frame(0, ups[i], vecs[i], 0, none);
        repeat (5) run_frame(0, 0, none, 0, none);

        // Two strobes in one frame: the second must be the one displayed.
        run_frame(0, 4, vecs[0], 20, vecs[4]);
        run_frame(0, 0, none, 0, none);

        // Reset while an update is pending: the pending data must be lost.
        wait_boundary();
        @(negedge clk);
        drive(vecs[8]);
        @(negedge clk);
        update = 1'b0;
        repeat (3) @(negedge clk);
        apply_reset(1);
        run_frame(1, 0, none, 0, none);
        run_frame(0, 0, none, 0, none);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
